// File: rtl/coolgirl_irq_if.sv
// Write-strobe / IRQ bus between mapper decode and the shared IRQ unit.
//   wr_en, wr_addr, wr_data : register write strobe from mapper decode
//   ppu_a12                 : raw PPU A12 (asynchronous to m2)
//   irq_n, irq_pending      : registered interrupt request and pending flag
//   counter_value           : live counter for readback
// master = mapper side, slave = IRQ unit side.
interface coolgirl_irq_if #(
    parameter int unsigned COUNTER_WIDTH = 16
);
    logic                     wr_en;
    logic [2:0]               wr_addr;
    logic [7:0]               wr_data;
    logic                     ppu_a12;
    logic                     irq_n;
    logic                     irq_pending;
    logic [COUNTER_WIDTH-1:0] counter_value;

    modport master (
        output wr_en, wr_addr, wr_data, ppu_a12,
        input  irq_n, irq_pending, counter_value
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, ppu_a12,
        output irq_n, irq_pending, counter_value
    );
endinterface

// File: rtl/coolgirl_irq_unit.sv
// Shared multicart IRQ generator: CPU down-counter (FME-7), CPU up-counter
// with reload (VRC/JY) and filtered PPU A12 scanline counter (MMC3).
// Ports:
//   m2      : CPU M2, sole clock (rising edge)
//   reset_n : asynchronous active-low reset
//   bus     : coolgirl_irq_if.slave (write strobe, ppu_a12, irq_n,
//             irq_pending, counter_value)
// Optional macro COOLGIRL_IRQ_VRC_PRESCALER_EN adds the VRC4 341/3 prescaler
// for CPU_UP mode; without it the prescale bit is stored but has no effect.
module coolgirl_irq_unit #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned A12_FILTER    = 3
) (
    input  logic          m2,
    input  logic          reset_n,
    coolgirl_irq_if.slave bus
);
    localparam int unsigned    CW   = COUNTER_WIDTH;
    localparam int unsigned    LCW  = 4;
    localparam logic [CW-1:0]  ONES = '1;
    localparam logic [LCW-1:0] FILT = LCW'(A12_FILTER);

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'd0,
        MODE_CPU_DOWN = 2'd1,
        MODE_CPU_UP   = 2'd2,
        MODE_SCANLINE = 2'd3
    } mode_e;

    logic [CW-1:0]  counter_q, counter_d;
    logic [CW-1:0]  latch_q, latch_d;
    mode_e          mode_q, mode_d;
    logic           enable_q, enable_d;
    logic           auto_reload_q, auto_reload_d;
    logic           prescale_q, prescale_d;
    logic           reload_q, reload_d;
    logic           pending_q, pending_d;
    logic           irq_n_q;
    logic [1:0]     sync_q;
    logic [LCW-1:0] low_cnt_q, low_cnt_d;
    logic           a12_s, a12_rise, up_tick, trigger, clear;
    logic [15:0]    latch_ext, counter_ext;

    // A12 filter: rise only counts after FILT synchronised low cycles
    assign a12_s     = sync_q[1];
    assign a12_rise  = a12_s && (low_cnt_q == FILT);
    assign low_cnt_d = a12_s ? '0 :
                       ((low_cnt_q == FILT) ? low_cnt_q : low_cnt_q + LCW'(1));

    // Byte-lane writes on a 16-bit view; bits above CW are dropped
    always_comb begin
        latch_ext   = 16'(latch_q);
        counter_ext = 16'(counter_q);
        if (bus.wr_en && bus.wr_addr == 3'd0) latch_ext[7:0]    = bus.wr_data;
        if (bus.wr_en && bus.wr_addr == 3'd1) latch_ext[15:8]   = bus.wr_data;
        if (bus.wr_en && bus.wr_addr == 3'd5) counter_ext[7:0]  = bus.wr_data;
        if (bus.wr_en && bus.wr_addr == 3'd6) counter_ext[15:8] = bus.wr_data;
    end

`ifdef COOLGIRL_IRQ_VRC_PRESCALER_EN
    localparam logic [8:0] PRESC_INIT = 9'd341;
    logic [8:0] presc_q, presc_d;
    logic       presc_tick;

    // Subtract 3 per m2; on underflow add 341 back and emit a tick
    always_comb begin
        presc_tick = 1'b0;
        presc_d    = presc_q - 9'd3;
        if (presc_q <= 9'd3) begin
            presc_d    = presc_q + 9'd338;
            presc_tick = 1'b1;
        end
        if (bus.wr_en && (bus.wr_addr == 3'd2 || bus.wr_addr == 3'd3)) begin
            presc_d = PRESC_INIT;
        end
    end

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) presc_q <= PRESC_INIT;
        else          presc_q <= presc_d;
    end

    assign up_tick = ~prescale_q | presc_tick;
`else
    logic unused_prescale;
    assign unused_prescale = prescale_q;
    assign up_tick         = 1'b1;
`endif

    // Next state: mode tick first, then register writes override it
    always_comb begin
        counter_d     = counter_q;
        latch_d       = CW'(latch_ext);
        mode_d        = mode_q;
        enable_d      = enable_q;
        auto_reload_d = auto_reload_q;
        prescale_d    = prescale_q;
        reload_d      = reload_q;
        trigger       = 1'b0;
        clear         = 1'b0;

        case (mode_q)
            MODE_CPU_DOWN: begin
                if (enable_q) begin
                    if (counter_q == '0) begin
                        trigger   = 1'b1;
                        counter_d = auto_reload_q ? latch_d : ONES;
                    end else begin
                        counter_d = counter_q - CW'(1);
                    end
                end
            end
            MODE_CPU_UP: begin
                if (enable_q && up_tick) begin
                    if (counter_q == ONES) begin
                        trigger   = 1'b1;
                        counter_d = latch_d;
                    end else begin
                        counter_d = counter_q + CW'(1);
                    end
                end
            end
            MODE_SCANLINE: begin
                if (a12_rise) begin
                    if (counter_q == '0 || reload_q) begin
                        counter_d = latch_d;
                        reload_d  = 1'b0;
                    end else begin
                        counter_d = counter_q - CW'(1);
                    end
                    trigger = enable_q && (counter_d == '0);
                end
            end
            default: ;
        endcase

        if (bus.wr_en) begin
            case (bus.wr_addr)
                3'd2: begin
                    mode_d        = mode_e'(bus.wr_data[1:0]);
                    enable_d      = bus.wr_data[2];
                    auto_reload_d = bus.wr_data[3];
                    prescale_d    = bus.wr_data[4];
                    clear         = ~bus.wr_data[2];
                end
                3'd3: clear    = 1'b1;
                3'd4: reload_d = 1'b1;
                3'd5, 3'd6: begin
                    // direct write discards the whole tick on this edge
                    counter_d = CW'(counter_ext);
                    reload_d  = reload_q;
                    trigger   = 1'b0;
                end
                default: ;
            endcase
        end

        // a trigger beats a same-edge acknowledge
        pending_d = trigger | (pending_q & ~clear);
    end

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            counter_q     <= '0;
            latch_q       <= '0;
            mode_q        <= MODE_IDLE;
            enable_q      <= 1'b0;
            auto_reload_q <= 1'b0;
            prescale_q    <= 1'b0;
            reload_q      <= 1'b0;
            pending_q     <= 1'b0;
            irq_n_q       <= 1'b1;
            sync_q        <= 2'b00;
            low_cnt_q     <= '0;
        end else begin
            counter_q     <= counter_d;
            latch_q       <= latch_d;
            mode_q        <= mode_d;
            enable_q      <= enable_d;
            auto_reload_q <= auto_reload_d;
            prescale_q    <= prescale_d;
            reload_q      <= reload_d;
            pending_q     <= pending_d;
            irq_n_q       <= ~pending_d;
            sync_q        <= {sync_q[0], bus.ppu_a12};
            low_cnt_q     <= low_cnt_d;
        end
    end

    assign bus.counter_value = counter_q;
    assign bus.irq_n         = irq_n_q;
    assign bus.irq_pending   = pending_q;
endmodule

// File: tb/tb_coolgirl_irq_unit.sv
// Bench for coolgirl_irq_unit: directed scenarios plus random traffic,
// all checked against a behavioural model of the register/counter rules.
module tb_coolgirl_irq_unit;
    localparam int unsigned CW   = 16;
    localparam int unsigned FILT = 3;
    localparam int          ONES = (1 << CW) - 1;
`ifdef COOLGIRL_IRQ_VRC_PRESCALER_EN
    localparam int EXP_PRESC_EDGE = 114;
`else
    localparam int EXP_PRESC_EDGE = 1;
`endif

    logic m2;
    logic reset_n;

    coolgirl_irq_if #(.COUNTER_WIDTH(CW)) bus ();

    coolgirl_irq_unit #(.COUNTER_WIDTH(CW), .A12_FILTER(FILT)) dut (
        .m2     (m2),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    // model state
    int m_cnt, m_latch, m_mode, m_div;
    bit m_en, m_ar, m_ps, m_rel, m_pend;
    bit pin_q[$];
    bit seen_q[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_latch = 0; m_mode = 0; m_div = 341;
        m_en = 0; m_ar = 0; m_ps = 0; m_rel = 0; m_pend = 0;
        pin_q.delete();
        seen_q.delete();
    endtask

    // One m2 rising edge of the specified behaviour
    task automatic model_edge(bit we, int a, int d, bit pin);
        int nl, cnt;
        bit trig, clr, rel, seen, qual, up;
        nl = m_latch;
        if (we && a == 0) nl = (m_latch & 'hFF00) | d;
        if (we && a == 1) nl = (m_latch & 'h00FF) | (d << 8);

        // A12 as seen by the unit is the pin two edges earlier
        seen = (pin_q.size() >= 2) ? pin_q[pin_q.size() - 2] : 1'b0;
        qual = 0;
        if (seen && seen_q.size() >= FILT) begin
            qual = 1;
            for (int i = 1; i <= FILT; i++)
                if (seen_q[seen_q.size() - i]) qual = 0;
        end

        up = 1;
`ifdef COOLGIRL_IRQ_VRC_PRESCALER_EN
        begin
            bit ptick;
            ptick = 0;
            m_div = m_div - 3;
            if (m_div <= 0) begin
                m_div = m_div + 341;
                ptick = 1;
            end
            if (m_ps) up = ptick;
            if (we && (a == 2 || a == 3)) m_div = 341;
        end
`endif

        cnt = m_cnt; trig = 0; clr = 0; rel = m_rel;
        case (m_mode)
            1: if (m_en) begin
                if (cnt == 0) begin trig = 1; cnt = m_ar ? nl : ONES; end
                else cnt = cnt - 1;
            end
            2: if (m_en && up) begin
                if (cnt == ONES) begin trig = 1; cnt = nl; end
                else cnt = cnt + 1;
            end
            3: if (qual) begin
                if (cnt == 0 || m_rel) begin cnt = nl; rel = 0; end
                else cnt = cnt - 1;
                if (cnt == 0 && m_en) trig = 1;
            end
            default: ;
        endcase

        if (we) begin
            case (a)
                2: begin
                    m_mode = d & 3;
                    m_en   = (d >> 2) & 1;
                    m_ar   = (d >> 3) & 1;
                    m_ps   = (d >> 4) & 1;
                    clr    = !m_en;
                end
                3: clr = 1;
                4: rel = 1;
                5: begin cnt = (m_cnt & 'hFF00) | d;        trig = 0; rel = m_rel; end
                6: begin cnt = (m_cnt & 'h00FF) | (d << 8); trig = 0; rel = m_rel; end
                default: ;
            endcase
        end

        m_cnt   = cnt;
        m_latch = nl;
        m_rel   = rel;
        if (trig)     m_pend = 1;
        else if (clr) m_pend = 0;
        pin_q.push_back(pin);
        seen_q.push_back(seen);
    endtask

    // Drive at negedge, clock one edge, compare at the next negedge
    task automatic step(bit we, int a, int d, bit pin);
        bus.wr_en   = we;
        bus.wr_addr = 3'(a);
        bus.wr_data = 8'(d);
        bus.ppu_a12 = pin;
        @(posedge m2);
        model_edge(we, a, d, pin);
        @(negedge m2);
        check("cnt",   32'(bus.counter_value), 32'(m_cnt));
        check("irq_n", 32'(bus.irq_n),         32'(!m_pend));
        check("pend",  32'(bus.irq_pending),   32'(m_pend));
    endtask

    task automatic idle(int n, bit pin);
        for (int i = 0; i < n; i++) step(0, 0, 0, pin);
    endtask

    initial begin
        int  found;
        int  edge_n;
        bit  we, pin;
        int  a, d;

        reset_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.ppu_a12 = 1'b0;
        model_reset();
        repeat (3) @(negedge m2);
        phase = "reset";
        check("cnt0",  32'(bus.counter_value), 32'h0);
        check("irqn0", 32'(bus.irq_n),         32'h1);
        check("pend0", 32'(bus.irq_pending),   32'h0);
        reset_n = 1'b1;
        idle(2, 0);

        // CPU_DOWN from 3, no auto reload
        phase = "down";
        step(1, 5, 3, 0); step(1, 6, 0, 0); step(1, 2, 'h05, 0);
        idle(3, 0);
        check("cnt_at0", 32'(bus.counter_value), 32'h0);
        check("no_irq",  32'(bus.irq_n),         32'h1);
        idle(1, 0);
        check("irq4",    32'(bus.irq_n),         32'h0);
        check("wrap",    32'(bus.counter_value), 32'hFFFF);
        step(1, 3, 0, 0);
        check("ack",     32'(bus.irq_n),         32'h1);
        step(1, 2, 0, 0);

        // collisions
        phase = "collide";
        step(1, 5, 1, 0); step(1, 6, 0, 0); step(1, 2, 'h05, 0);
        idle(1, 0);
        step(1, 3, 0, 0);
        check("trig_beats_ack", 32'(bus.irq_n), 32'h0);
        step(1, 5, 'h5A, 0);
        check("wr_beats_tick", 32'(bus.counter_value), 32'hFF5A);
        step(1, 6, 'h12, 0);
        check("wr_hi", 32'(bus.counter_value), 32'h125A);
        step(1, 2, 0, 0);
        check("dis_clr", 32'(bus.irq_n), 32'h1);

        // CPU_UP wrap/reload
        phase = "up";
        step(1, 0, 'hFD, 0); step(1, 1, 'hFF, 0);
        step(1, 5, 'hFD, 0); step(1, 6, 'hFF, 0);
        step(1, 2, 'h06, 0);
        idle(2, 0);
        check("no_irq2", 32'(bus.irq_n), 32'h1);
        idle(1, 0);
        check("irq3",    32'(bus.irq_n),         32'h0);
        check("reload",  32'(bus.counter_value), 32'hFFFD);
        step(1, 3, 0, 0);
        idle(2, 0);
        check("irq6",    32'(bus.irq_n),         32'h0);
        check("reload2", 32'(bus.counter_value), 32'hFFFD);
        step(1, 2, 0, 0);

        // SCANLINE with filtered A12
        phase = "scan";
        step(1, 0, 2, 0); step(1, 1, 0, 0); step(1, 4, 0, 0);
        step(1, 2, 'h07, 0);
        idle(4, 0);
        for (int p = 0; p < 3; p++) begin
            step(0, 0, 0, 1);
            idle(4, 0);
            check("line_cnt", 32'(bus.counter_value), 32'(2 - p));
            check("line_irq", 32'(bus.irq_n), (p == 2) ? 32'h0 : 32'h1);
        end
        step(1, 3, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, (i % 2) == 1);
        idle(5, 0);
        check("filtered", 32'(bus.counter_value), 32'h2);
        check("filt_irq", 32'(bus.irq_n),         32'h1);
        step(1, 2, 0, 0);

        // asynchronous reset while irq_n is low
        phase = "areset";
        step(1, 5, 2, 0); step(1, 6, 0, 0); step(1, 2, 'h05, 0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            idle(1, 0);
            if (bus.irq_n === 1'b0) found = 1;
        end
        check("mid_irq", 32'(found), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("async_irqn", 32'(bus.irq_n),         32'h1);
        check("async_cnt",  32'(bus.counter_value), 32'h0);
        @(negedge m2);
        reset_n = 1'b1;
        model_reset();
        idle(5, 0);
        check("idle_irqn", 32'(bus.irq_n),         32'h1);
        check("idle_cnt",  32'(bus.counter_value), 32'h0);

        // prescaled CPU_UP first IRQ position
        phase = "presc";
        step(1, 5, 'hFF, 0); step(1, 6, 'hFF, 0);
        step(1, 2, 'h16, 0);
        edge_n = 0;
        for (int i = 1; i <= 200 && edge_n == 0; i++) begin
            idle(1, 0);
            if (bus.irq_n === 1'b0) edge_n = i;
        end
        check("first_edge", 32'(edge_n), 32'(EXP_PRESC_EDGE));
        step(1, 2, 0, 0);

        // random traffic against the model
        phase = "rand";
        for (int i = 0; i < 1500; i++) begin
            we  = ($urandom_range(0, 3) == 0);
            a   = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 255));
            if (a == 6 && $urandom_range(0, 1) == 1) d = 0;
            if (a == 2 && $urandom_range(0, 3) != 0) d = d | 4;
            pin = ($urandom_range(0, 4) == 0);
            step(we, a, d, pin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
